// File: rtl/mlp_pkg.sv
// Shared types and per-layer configuration for the MLP layer sequencer.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    ACT,
    FIN
  } state_e;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_HSIG
  } act_e;

  localparam int unsigned MAX_LAYERS = 8;

  // Active node counts per layer; unconfigured layers keep every node.
  localparam int unsigned LAYER_IN  [MAX_LAYERS] = '{10, 5, 8, 255, 255, 255, 255, 255};
  localparam int unsigned LAYER_OUT [MAX_LAYERS] = '{5, 8, 1, 255, 255, 255, 255, 255};
  localparam act_e        LAYER_ACT [MAX_LAYERS] = '{ACT_HSIG, ACT_HSIG, ACT_NONE, ACT_NONE,
                                                     ACT_NONE, ACT_NONE, ACT_NONE, ACT_NONE};

  // True when node idx lies inside the active width of a layer.
  function automatic logic keep_node(input int unsigned idx, input int unsigned limit);
    return idx < limit;
  endfunction

endpackage

// File: rtl/mlp_act.sv
// Single-node activation: identity, ReLU or hard sigmoid on a signed
// fixed-point word with DW/2 fractional bits.
module mlp_act
  import mlp_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] x,
  input  act_e          mode,
  output logic [DW-1:0] y
);

  localparam logic signed [DW+1:0] HALF = (DW+2)'(1 << (DW/2 - 1));
  localparam logic signed [DW+1:0] ONE  = (DW+2)'(1 << (DW/2));

  logic signed [DW+1:0] wide;
  logic signed [DW+1:0] hsig;

  // Hard sigmoid is evaluated two bits wider than the node word so the
  // offset add never wraps, then clamped into [0, 1.0].
  always_comb begin
    wide = {{2{x[DW-1]}}, x};
    hsig = (wide >>> 2) + HALF;
    y    = x;
    case (mode)
      ACT_RELU: begin
        if (x[DW-1]) y = '0;
      end
      ACT_HSIG: begin
        if (hsig[DW+1])      y = '0;
        else if (hsig > ONE) y = ONE[DW-1:0];
        else                 y = hsig[DW-1:0];
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/mlp_sequencer.sv
// Layer sequencer for a small MLP: loads the input vector, hands each
// layer to an external linear engine, applies the per-layer activation
// and publishes the final vector.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned MAX_NODES  = 10,
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned DW         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [MAX_NODES*DW-1:0] in_nodes,
  output logic                    busy,
  output logic                    done,
  output logic [MAX_NODES*DW-1:0] out_nodes,
  output logic                    lin_start,
  output logic [2:0]              lin_layer,
  output logic [MAX_NODES*DW-1:0] lin_din,
  input  logic                    lin_done,
  input  logic [MAX_NODES*DW-1:0] lin_dout
);

  localparam int unsigned VW = MAX_NODES * DW;

  state_e        state_q, state_d;
  logic [2:0]    layer_q, layer_d;
  logic [VW-1:0] left_q, left_d;
  logic [VW-1:0] res_q, res_d;
  logic [VW-1:0] out_q, out_d;
  logic          done_q, done_d;
  logic [VW-1:0] act_y;
  act_e          act_mode;

  assign act_mode = LAYER_ACT[layer_q];

  for (genvar g = 0; g < MAX_NODES; g++) begin : g_act
    mlp_act #(.DW(DW)) u_act (
      .x    (res_q[g*DW +: DW]),
      .mode (act_mode),
      .y    (act_y[g*DW +: DW])
    );
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      layer_q <= '0;
      left_q  <= '0;
      res_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      left_q  <= left_d;
      res_q   <= res_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath updates; abort overrides every other update.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    left_d  = left_q;
    res_d   = res_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        for (int unsigned i = 0; i < MAX_NODES; i++) begin
          left_d[i*DW +: DW] = keep_node(i, LAYER_IN[0]) ? in_nodes[i*DW +: DW] : '0;
        end
        layer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        if (lin_done) begin
          res_d   = lin_dout;
          state_d = ACT;
        end
      end
      ACT: begin
        for (int unsigned i = 0; i < MAX_NODES; i++) begin
          left_d[i*DW +: DW] = keep_node(i, LAYER_OUT[layer_q]) ? act_y[i*DW +: DW] : '0;
        end
        if (32'(layer_q) + 32'd1 < NUM_LAYERS) begin
          layer_d = layer_q + 3'd1;
          state_d = RUN;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        out_d   = left_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      layer_d = layer_q;
      left_d  = left_q;
      res_d   = res_q;
      out_d   = out_q;
      done_d  = 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign lin_start = (state_q == RUN);
  assign lin_layer = layer_q;
  assign lin_din   = left_q;
  assign out_nodes = out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer with a behavioural engine and a
// plain-arithmetic reference model of the layer pipeline.
module tb_mlp_sequencer;

  localparam int MN = 10;
  localparam int W  = 16;
  localparam int NL = 3;
  localparam int VW = MN * W;
  typedef logic [VW-1:0] vec_t;

  // Layer shape as seen from outside: active inputs, active outputs,
  // activation (0 identity, 1 relu, 2 hard sigmoid).
  localparam int TB_IN  [NL] = '{10, 5, 8};
  localparam int TB_OUT [NL] = '{5, 8, 1};
  localparam int TB_ACT [NL] = '{2, 2, 0};

  logic clk, reset, start, abort, busy, done, lin_start, lin_done;
  logic [2:0] lin_layer;
  vec_t in_nodes, out_nodes, lin_din, lin_dout;

  logic [W-1:0] ax, ay;
  mlp_pkg::act_e amode;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  vec_t stim_in;
  vec_t stim_res [NL];
  int   stim_dly [NL];

  vec_t obs_din [NL];
  int   obs_layer [NL];
  int   obs_lat, obs_extra_done;
  bit   obs_timeout, obs_act_bad, obs_busy_at_done, obs_busy_after;
  bit   k_busy, k_ls, k_done;
  vec_t k_out;

  mlp_sequencer #(.MAX_NODES(MN), .NUM_LAYERS(NL), .DW(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_nodes  (in_nodes),
    .busy      (busy),
    .done      (done),
    .out_nodes (out_nodes),
    .lin_start (lin_start),
    .lin_layer (lin_layer),
    .lin_din   (lin_din),
    .lin_done  (lin_done),
    .lin_dout  (lin_dout)
  );

  mlp_act #(.DW(W)) u_act_chk (.x(ax), .mode(amode), .y(ay));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_act(input logic [W-1:0] x, input int mode);
    int v;
    v = int'($signed(x));
    if (mode == 1) return (v < 0) ? '0 : x;
    if (mode == 2) begin
      v = (v >>> 2) + 128;
      if (v < 0)   v = 0;
      if (v > 256) v = 256;
      return W'(v);
    end
    return x;
  endfunction

  function automatic vec_t ref_mask(input vec_t v, input int n);
    for (int i = n; i < MN; i++) v[i*W +: W] = '0;
    return v;
  endfunction

  // Vector presented to the engine for layer l (l == NL gives the result).
  function automatic vec_t ref_left(input int l);
    vec_t v, a;
    v = ref_mask(stim_in, TB_IN[0]);
    for (int j = 0; j < l; j++) begin
      for (int i = 0; i < MN; i++) a[i*W +: W] = ref_act(stim_res[j][i*W +: W], TB_ACT[j]);
      v = ref_mask(a, TB_OUT[j]);
    end
    return v;
  endfunction

  function automatic int ref_lat();
    int s = 3;
    for (int l = 0; l < NL; l++) s += stim_dly[l] + 1;
    return s;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < MN; i++) begin
      if ($urandom_range(0, 1) == 1) v[i*W +: W] = W'($urandom);
      else v[i*W +: W] = W'($urandom_range(0, 4095)) - W'(2048);
    end
    return v;
  endfunction

  // Runs one inference with a behavioural engine; records what was seen.
  // kill_layer >= 0 stops at that layer's first RUN cycle by abort (0) or reset (1).
  task automatic drive_run(input bit noise, input int kill_layer, input int kill_kind,
                           input bit start_in_fin);
    int t0, w;
    obs_timeout = 0; obs_act_bad = 0; obs_extra_done = 0; obs_lat = -1;
    @(negedge clk); in_nodes = stim_in; start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    for (int l = 0; l < NL; l++) begin
      w = 0;
      while (lin_start !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      if (w >= 40) begin obs_timeout = 1; return; end
      obs_layer[l] = int'(lin_layer);
      obs_din[l]   = lin_din;
      if (l == kill_layer) begin
        if (kill_kind == 0) begin abort = 1'b1; @(negedge clk); abort = 1'b0; end
        else begin reset = 1'b0; #1; end
        k_busy = busy; k_ls = lin_start; k_done = done; k_out = out_nodes;
        return;
      end
      for (int k = 1; k < stim_dly[l]; k++) begin
        if (noise) start = 1'($urandom_range(0, 1));
        lin_dout = rand_vec();
        @(negedge clk);
      end
      start = 1'b0; lin_done = 1'b1; lin_dout = stim_res[l];
      @(negedge clk);
      if (lin_start !== 1'b0) obs_act_bad = 1;
      lin_done = noise; lin_dout = rand_vec();
      @(negedge clk);
      lin_done = 1'b0;
    end
    if (start_in_fin) start = 1'b1;
    w = 0;
    while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    if (w >= 40) begin obs_timeout = 1; start = 1'b0; return; end
    obs_lat = cyc - t0;
    obs_busy_at_done = busy;
    if (start_in_fin) begin
      @(negedge clk); obs_busy_after = busy; start = 1'b0; abort = 1'b1;
      @(negedge clk); abort = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done === 1'b1) obs_extra_done++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (lin_start !== 1'b0) begin n_fail++; $display("FAIL reset_lin_start: got %0b want 0", lin_start); end
    n_checks++; if (out_nodes !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out_nodes); end
    n_checks++; if (lin_din !== '0) begin n_fail++; $display("FAIL reset_lin_din: got %h want 0", lin_din); end
    n_checks++; if (lin_layer !== 3'd0) begin n_fail++; $display("FAIL reset_layer: got %0d want 0", lin_layer); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_latency();
    vec_t e = '0;
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin
      stim_dly[l] = 4;
      for (int i = 0; i < MN; i++) stim_res[l][i*W +: W] = 16'h0100;
    end
    e[W-1:0] = 16'h0100;
    drive_run(1'b0, -1, 0, 1'b0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL fixed_timeout: engine or done never seen"); end
    n_checks++; if (obs_lat !== 18) begin n_fail++; $display("FAIL fixed_latency: got %0d want 18", obs_lat); end
    n_checks++; if (out_nodes !== e) begin n_fail++; $display("FAIL fixed_out: got %h want %h", out_nodes, e); end
    n_checks++; if (obs_extra_done !== 0) begin n_fail++; $display("FAIL fixed_done_pulse: extra %0d want 0", obs_extra_done); end
  endtask

  task automatic test_hsig_boundaries();
    logic [W-1:0] r0 [5] = '{16'hFC00, 16'h0400, 16'h0000, 16'h7FFF, 16'h8000};
    logic [W-1:0] e0 [5] = '{16'h0000, 16'h0100, 16'h0080, 16'h0100, 16'h0000};
    logic [W-1:0] r1 [8] = '{16'h0200, 16'hFE00, 16'h01FF, 16'hFE01,
                             16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    vec_t e = '0;
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin
      stim_dly[l] = $urandom_range(1, 3);
      stim_res[l] = rand_vec();
    end
    for (int i = 0; i < 5; i++) begin
      stim_res[0][i*W +: W] = r0[i];
      e[i*W +: W] = e0[i];
    end
    for (int i = 0; i < 8; i++) stim_res[1][i*W +: W] = r1[i];
    drive_run(1'b0, -1, 0, 1'b0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL hsig_timeout: engine or done never seen"); end
    n_checks++; if (obs_din[1] !== e) begin n_fail++; $display("FAIL hsig_layer0: got %h want %h", obs_din[1], e); end
    n_checks++; if (obs_din[2] !== ref_left(2)) begin n_fail++; $display("FAIL hsig_layer1: got %h want %h", obs_din[2], ref_left(2)); end
    n_checks++; if (out_nodes !== ref_left(NL)) begin n_fail++; $display("FAIL hsig_out: got %h want %h", out_nodes, ref_left(NL)); end
  endtask

  task automatic test_relu();
    amode = mlp_pkg::ACT_RELU;
    ax = 16'hFF00; #1;
    n_checks++; if (ay !== 16'h0000) begin n_fail++; $display("FAIL relu_neg: got %h want 0000", ay); end
    ax = 16'h0180; #1;
    n_checks++; if (ay !== 16'h0180) begin n_fail++; $display("FAIL relu_pos: got %h want 0180", ay); end
    for (int k = 0; k < 16; k++) begin
      ax = W'($urandom); #1;
      n_checks++; if (ay !== ref_act(ax, 1)) begin n_fail++; $display("FAIL relu_rand: x %h got %h want %h", ax, ay, ref_act(ax, 1)); end
    end
    amode = mlp_pkg::ACT_NONE;
    ax = W'($urandom); #1;
    n_checks++; if (ay !== ax) begin n_fail++; $display("FAIL none_ident: got %h want %h", ay, ax); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      stim_in = rand_vec();
      for (int l = 0; l < NL; l++) begin
        stim_dly[l] = $urandom_range(1, 6);
        stim_res[l] = rand_vec();
      end
      drive_run(1'b1, -1, 0, 1'b0);
      n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL rand_timeout: run %0d stalled", r); end
      for (int l = 0; l < NL; l++) begin
        n_checks++; if (obs_layer[l] !== l) begin n_fail++; $display("FAIL rand_layer: run %0d got %0d want %0d", r, obs_layer[l], l); end
        n_checks++; if (obs_din[l] !== ref_left(l)) begin n_fail++; $display("FAIL rand_din: run %0d layer %0d got %h want %h", r, l, obs_din[l], ref_left(l)); end
      end
      n_checks++; if (obs_act_bad) begin n_fail++; $display("FAIL rand_act_lin_start: got 1 want 0 in ACT"); end
      n_checks++; if (obs_lat !== ref_lat()) begin n_fail++; $display("FAIL rand_latency: got %0d want %0d", obs_lat, ref_lat()); end
      n_checks++; if (out_nodes !== ref_left(NL)) begin n_fail++; $display("FAIL rand_out: got %h want %h", out_nodes, ref_left(NL)); end
      n_checks++; if (obs_extra_done !== 0) begin n_fail++; $display("FAIL rand_done_pulse: extra %0d want 0", obs_extra_done); end
    end
  endtask

  task automatic test_mask();
    vec_t e;
    logic [VW-5*W-1:0] upper;
    for (int i = 0; i < MN; i++) e[i*W +: W] = 16'h0100;
    stim_in = e;
    for (int l = 0; l < NL; l++) begin
      stim_dly[l] = 3;
      stim_res[l] = rand_vec();
    end
    drive_run(1'b1, -1, 0, 1'b0);
    upper = obs_din[1][VW-1:5*W];
    n_checks++; if (obs_din[0] !== e) begin n_fail++; $display("FAIL mask_layer0: got %h want %h", obs_din[0], e); end
    n_checks++; if (upper !== '0) begin n_fail++; $display("FAIL mask_layer1_upper: got %h want 0", upper); end
    n_checks++; if (obs_extra_done !== 0) begin n_fail++; $display("FAIL mask_done_pulse: extra %0d want 0", obs_extra_done); end
  endtask

  task automatic test_abort();
    vec_t prev;
    int seen;
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin stim_dly[l] = 2; stim_res[l] = rand_vec(); end
    drive_run(1'b0, -1, 0, 1'b0);
    prev = ref_left(NL);
    n_checks++; if (out_nodes !== prev) begin n_fail++; $display("FAIL abort_pre_out: got %h want %h", out_nodes, prev); end
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) stim_res[l] = rand_vec();
    drive_run(1'b0, 1, 0, 1'b0);
    n_checks++; if (k_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", k_busy); end
    n_checks++; if (k_ls !== 1'b0) begin n_fail++; $display("FAIL abort_lin_start: got %0b want 0", k_ls); end
    n_checks++; if (k_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b want 0", k_done); end
    n_checks++; if (k_out !== prev) begin n_fail++; $display("FAIL abort_out: got %h want %h", k_out, prev); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done === 1'b1) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_prio: busy %0b want 0", busy); end
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin stim_dly[l] = $urandom_range(1, 5); stim_res[l] = rand_vec(); end
    drive_run(1'b0, -1, 0, 1'b0);
    n_checks++; if (obs_lat !== ref_lat()) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want %0d", obs_lat, ref_lat()); end
    n_checks++; if (out_nodes !== ref_left(NL)) begin n_fail++; $display("FAIL abort_rerun_out: got %h want %h", out_nodes, ref_left(NL)); end
  endtask

  task automatic test_back_to_back();
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin stim_dly[l] = $urandom_range(1, 4); stim_res[l] = rand_vec(); end
    drive_run(1'b0, -1, 0, 1'b1);
    n_checks++; if (obs_lat !== ref_lat()) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", obs_lat, ref_lat()); end
    n_checks++; if (obs_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL b2b_fin_start: busy %0b want 0", obs_busy_at_done); end
    n_checks++; if (obs_busy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_start: busy %0b want 1", obs_busy_after); end
    n_checks++; if (out_nodes !== ref_left(NL)) begin n_fail++; $display("FAIL b2b_out: got %h want %h", out_nodes, ref_left(NL)); end
  endtask

  task automatic test_reset_mid_run();
    stim_in = rand_vec();
    for (int l = 0; l < NL; l++) begin stim_dly[l] = 3; stim_res[l] = rand_vec(); end
    drive_run(1'b0, 1, 1, 1'b0);
    n_checks++; if (k_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0b want 0", k_busy); end
    n_checks++; if (k_ls !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lin_start: got %0b want 0", k_ls); end
    n_checks++; if (k_out !== '0) begin n_fail++; $display("FAIL rst_mid_out: got %h want 0", k_out); end
    n_checks++; if (lin_din !== '0) begin n_fail++; $display("FAIL rst_mid_left: got %h want 0", lin_din); end
    n_checks++; if (lin_layer !== 3'd0) begin n_fail++; $display("FAIL rst_mid_layer: got %0d want 0", lin_layer); end
    @(negedge clk); reset = 1'b1; lin_done = 1'b1; lin_dout = rand_vec();
    @(negedge clk); lin_done = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stale_done_busy: got %0b want 0", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_stale_done_pulse: got %0b want 0", done); end
    n_checks++; if (out_nodes !== '0) begin n_fail++; $display("FAIL rst_stale_out: got %h want 0", out_nodes); end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; lin_done = 1'b0; lin_dout = '0; in_nodes = '0;
    ax = '0; amode = mlp_pkg::ACT_NONE;
    test_reset();
    test_fixed_latency();
    test_hsig_boundaries();
    test_relu();
    test_random();
    test_mask();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
